// File: rtl/times_table_pkg.sv
// Shared constants, FSM encoding and address helper for the times-table AXI4-Lite arbiter.
package times_table_pkg;

    localparam int TT_OP_W  = 3;
    localparam int TT_RES_W = 6;
    localparam int TT_OFF_W = 2 * TT_OP_W + 2;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_AR   = 2'd1;
    localparam logic [1:0] ST_R    = 2'd2;

    // Table is laid out row-major on a, one 32-bit word per entry
    function automatic logic [TT_OFF_W-1:0] tt_offset(input logic [TT_OP_W-1:0] op_a,
                                                      input logic [TT_OP_W-1:0] op_b);
        return {op_a, op_b, 2'b00};
    endfunction

endpackage

// File: rtl/times_table_axi_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after the last-served index, wrapping.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx
);

    logic found_s;
    int   cand_s;

    // Scan N_REQ positions starting one past the last winner
    always_comb begin
        grant   = '0;
        idx     = '0;
        found_s = 1'b0;
        cand_s  = 0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand_s = (int'(last) + off) % N_REQ;
            if (!found_s && req[cand_s]) begin
                found_s       = 1'b1;
                grant[cand_s] = 1'b1;
                idx           = IDX_W'(cand_s);
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/times_table_axi_arbiter.sv
// Shares one AXI4-Lite times-table ROM between N_REQ requesters, one outstanding read at a time.
module times_table_axi_arbiter
    import times_table_pkg::*;
#(
    parameter int                N_REQ  = 2,
    parameter int                ADDR_W = 8,
    parameter logic [ADDR_W-1:0] BASE   = 8'h00
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [TT_OP_W*N_REQ-1:0]  a,
    input  logic [TT_OP_W*N_REQ-1:0]  b,
    output logic [N_REQ-1:0]          done,
    output logic [TT_RES_W*N_REQ-1:0] rslt,
    output logic [N_REQ-1:0]          err,
    output logic [ADDR_W-1:0]         m_araddr,
    output logic                      m_arvalid,
    input  logic                      m_arready,
    input  logic [31:0]               m_rdata,
    input  logic [1:0]                m_rresp,
    input  logic                      m_rvalid,
    output logic                      m_rready
);

    localparam int IDX_W = $clog2(N_REQ > 1 ? N_REQ : 2);

    logic [1:0]                state_r;
    logic [IDX_W-1:0]          rr_r;
    logic [IDX_W-1:0]          win_r;
    logic [ADDR_W-1:0]         araddr_r;
    logic                      arvalid_r;
    logic                      rready_r;
    logic [N_REQ-1:0]          done_r;
    logic [TT_RES_W*N_REQ-1:0] rslt_r;
    logic [N_REQ-1:0]          err_r;

    logic [N_REQ-1:0]   gnt_s;
    logic [IDX_W-1:0]   gnt_idx_s;
    logic               gnt_any_s;
    logic [TT_OP_W-1:0] a_sel_s;
    logic [TT_OP_W-1:0] b_sel_s;
    logic [ADDR_W-1:0]  addr_s;
    logic               rd_ok_s;
    logic               rdata_unused_s;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req   (req),
        .last  (rr_r),
        .grant (gnt_s),
        .idx   (gnt_idx_s)
    );

    // Winner operand select and table address (wraps in ADDR_W bits)
    always_comb begin
        gnt_any_s      = |gnt_s;
        a_sel_s        = a[int'(gnt_idx_s)*TT_OP_W +: TT_OP_W];
        b_sel_s        = b[int'(gnt_idx_s)*TT_OP_W +: TT_OP_W];
        addr_s         = BASE + ADDR_W'(tt_offset(a_sel_s, b_sel_s));
        rd_ok_s        = (m_rresp == AXI_RESP_OKAY);
        rdata_unused_s = ^m_rdata[31:TT_RES_W];
    end

    // Transaction FSM: IDLE grants, AR waits for address handshake, R waits for data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            rr_r      <= IDX_W'(N_REQ - 1);
            win_r     <= '0;
            araddr_r  <= '0;
            arvalid_r <= 1'b0;
            rready_r  <= 1'b0;
            done_r    <= '0;
            rslt_r    <= '0;
            err_r     <= '0;
        end else begin
            done_r <= '0;
            case (state_r)
                ST_IDLE: begin
                    if (gnt_any_s) begin
                        win_r     <= gnt_idx_s;
                        araddr_r  <= addr_s;
                        arvalid_r <= 1'b1;
                        state_r   <= ST_AR;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_AR: begin
                    if (m_arready) begin
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                        state_r   <= ST_R;
                    end else begin
                        state_r <= ST_AR;
                    end
                end
                ST_R: begin
                    if (m_rvalid) begin
                        rready_r <= 1'b0;
                        rslt_r[int'(win_r)*TT_RES_W +: TT_RES_W] <=
                            rd_ok_s ? m_rdata[TT_RES_W-1:0] : {TT_RES_W{1'b0}};
                        err_r[win_r]  <= ~rd_ok_s;
                        done_r[win_r] <= 1'b1;
                        rr_r          <= win_r;
                        state_r       <= ST_IDLE;
                    end else begin
                        state_r <= ST_R;
                    end
                end
                default: begin
                    arvalid_r <= 1'b0;
                    rready_r  <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_araddr  = araddr_r;
    assign m_arvalid = arvalid_r;
    assign m_rready  = rready_r;
    assign done      = done_r;
    assign rslt      = rslt_r;
    assign err       = err_r;

endmodule
